// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period, high time and integer duty cycle (%) of a
// slow, possibly asynchronous signal in clock_in cycles; duty uses a serial divider.
module clock_period_meter #(
  parameter int CNT_WIDTH   = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock_in,
  input  logic                 Rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic [6:0]           duty_o,
  output logic                 stalled,
  output logic                 overrun
);

  localparam int DW = CNT_WIDTH + 7;
  localparam int SW = $clog2(DW + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0] HUNDRED = DW'(100);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q, s_d, rise;
  logic [CNT_WIDTH-1:0]   cnt, hcnt, cap_period, cap_high, rem, trial;
  logic [DW-1:0]          quo, dividend;
  logic [SW-1:0]          div_step;
  logic                   busy, div_done, trial_ok;
  logic [CNT_WIDTH:0]     shifted;

  // The synchroniser is left out of reset so a reset never fabricates a rising edge.
  always_ff @(posedge clock_in) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    s_d    <= sync_q[SYNC_STAGES-1];
  end

  assign s_q      = sync_q[SYNC_STAGES-1];
  assign rise     = s_q & ~s_d;
  assign dividend = {7'd0, hcnt} * HUNDRED;
  assign div_done = busy && (div_step == SW'(DW));
  assign shifted  = {rem, quo[DW-1]};
  assign trial_ok = shifted >= {1'b0, cap_period};
  assign trial    = shifted[CNT_WIDTH-1:0] - cap_period;

  always_ff @(posedge clock_in) begin
    if (!Rst_n) begin
      state      <= WAIT_FIRST;
      cnt        <= '0;
      hcnt       <= '0;
      cap_period <= '0;
      cap_high   <= '0;
      rem        <= '0;
      quo        <= '0;
      div_step   <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      period_o   <= '0;
      high_o     <= '0;
      duty_o     <= '0;
      stalled    <= 1'b0;
      overrun    <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      div_step <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      stalled  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid <= 1'b0;
      // The divider finishing this cycle frees it for a capture in the same cycle.
      if (busy) begin
        if (div_done) begin
          busy     <= 1'b0;
          valid    <= 1'b1;
          period_o <= cap_period;
          high_o   <= cap_high;
          duty_o   <= quo[6:0];
          stalled  <= 1'b0;
        end else begin
          rem      <= trial_ok ? trial : shifted[CNT_WIDTH-1:0];
          quo      <= {quo[DW-2:0], trial_ok};
          div_step <= div_step + SW'(1);
        end
      end

      case (state)
        IDLE: state <= WAIT_FIRST;
        WAIT_FIRST: begin
          if (rise) begin
            cnt   <= CNT_WIDTH'(1);
            hcnt  <= CNT_WIDTH'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt  <= CNT_WIDTH'(1);
            hcnt <= CNT_WIDTH'(1);
            if (busy && !div_done) begin
              overrun <= 1'b1;
            end else begin
              busy       <= 1'b1;
              div_step   <= '0;
              rem        <= '0;
              quo        <= dividend;
              cap_period <= cnt;
              cap_high   <= hcnt;
            end
          end else if (cnt == CNT_LAST) begin
            // The counter would reach its maximum on this edge: give up on this period.
            stalled <= 1'b1;
            cnt     <= '0;
            hcnt    <= '0;
            state   <= WAIT_FIRST;
          end else begin
            cnt  <= cnt + CNT_WIDTH'(1);
            hcnt <= hcnt + CNT_WIDTH'(s_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter with CNT_WIDTH=8: directed and random waveforms are
// checked every cycle against an event model built from rise timestamps.
module tb_clock_period_meter;

  localparam int W     = 8;
  localparam int LAT   = W + 8;
  localparam int STALL = (1 << W) - 2;
  localparam int MAXC  = 16384;

  logic         clock_in, rst_n, en, sig_in;
  logic         valid, stalled, overrun;
  logic [W-1:0] period_o, high_o;
  logic [6:0]   duty_o;

  clock_period_meter #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clock_in(clock_in),
    .Rst_n   (rst_n),
    .en      (en),
    .sig_in  (sig_in),
    .valid   (valid),
    .period_o(period_o),
    .high_o  (high_o),
    .duty_o  (duty_o),
    .stalled (stalled),
    .overrun (overrun)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  typedef struct {
    int t;
    int p;
    int h;
    int d;
  } result_t;

  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  bit      wave  [0:MAXC-1];
  bit      en_h  [0:MAXC-1];
  bit      rst_h [0:MAXC-1];
  result_t pend[$];
  bit      off, armed;
  int      last_rise, div_free_at;
  int      exp_period, exp_high, exp_duty;
  bit      exp_valid, exp_stalled, exp_overrun;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s at edge %0d: observed %0d expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // Edge c sees en/Rst_n driven one iteration earlier and sig_in three iterations
  // earlier (two synchroniser flops plus the edge detector).
  task automatic model_edge(input int c);
    bit      rise;
    int      p, h;
    result_t r;
    exp_valid = 1'b0;
    rise = (c >= 4) && wave[c-3] && !wave[c-4];
    if (!rst_h[c-1]) begin
      off = 0; armed = 0; div_free_at = 0;
      pend.delete();
      exp_period = 0; exp_high = 0; exp_duty = 0;
      exp_stalled = 0; exp_overrun = 0;
    end else if (!en_h[c-1]) begin
      off = 1; armed = 0; div_free_at = 0;
      pend.delete();
      exp_stalled = 0; exp_overrun = 0;
    end else if (off) begin
      off = 0;
    end else begin
      if (pend.size() > 0 && pend[0].t == c) begin
        r = pend.pop_front();
        exp_valid = 1'b1;
        exp_period = r.p; exp_high = r.h; exp_duty = r.d;
        exp_stalled = 0;
      end
      if (rise) begin
        if (armed) begin
          p = c - last_rise;
          h = 0;
          for (int k = last_rise - 3; k <= c - 4; k++) h += int'(wave[k]);
          if (c >= div_free_at) begin
            r.t = c + LAT; r.p = p; r.h = h; r.d = (h * 100) / p;
            pend.push_back(r);
            div_free_at = c + LAT;
          end else begin
            exp_overrun = 1;
          end
        end
        armed = 1;
        last_rise = c;
      end else if (armed && (c - last_rise == STALL)) begin
        exp_stalled = 1;
        armed = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s);
    if (cyc >= MAXC - 2) begin
      $display("[TB] FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC - 2);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    rst_n = r; en = e; sig_in = s;
    rst_h[cyc] = r; en_h[cyc] = e; wave[cyc] = s;
    @(posedge clock_in);
    #1;
    cyc++;
    model_edge(cyc);
    checkOutput("valid",    int'(valid),    int'(exp_valid));
    checkOutput("period_o", int'(period_o), exp_period);
    checkOutput("high_o",   int'(high_o),   exp_high);
    checkOutput("duty_o",   int'(duty_o),   exp_duty);
    checkOutput("stalled",  int'(stalled),  int'(exp_stalled));
    checkOutput("overrun",  int'(overrun),  int'(exp_overrun));
  endtask

  task automatic run_wave(input int h, input int l, input int n, input int rst_at);
    for (int k = 0; k < n * (h + l); k++)
      applyStimulus((k == rst_at) ? 1'b0 : 1'b1, 1'b1, (k % (h + l)) < h);
  endtask

  initial begin
    int p, h;
    $display("[TB] clock_period_meter bench start");
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);

    run_wave(20, 20, 8, -1);
    run_wave(15, 35, 5, -1);
    run_wave(10, 20, 5, -1);
    for (int i = 0; i < 15; i++) begin
      p = int'($urandom_range(24, 110));
      h = int'($urandom_range(1, p - 1));
      run_wave(h, p - h, 1, -1);
    end

    // Period 3 forces decimation and a sticky overrun, then en=0 clears it.
    run_wave(1, 2, 40, -1);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    run_wave(20, 20, 4, -1);

    // A lone rise followed by a long low stretch stalls, then measurement resumes.
    run_wave(20, 300, 1, -1);
    run_wave(20, 20, 4, -1);

    // Reset pulse lands while the second period's divide is in flight.
    run_wave(20, 20, 5, 48);

    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(2, 60));
      h = int'($urandom_range(1, p - 1));
      run_wave(h, p - h, 1, -1);
    end
    repeat (30) applyStimulus(1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
